// File: rtl/arp_lookup_ctrl.sv
// ARP lookup controller: resolves a next-hop IP to a MAC address by applying
// broadcast/subnet/gateway rules, querying the ARP cache and, on a miss,
// requesting ARP transmissions and polling the cache until resolved or the
// retry budget runs out. One lookup is in flight at a time.
module arp_lookup_ctrl #(
    parameter int unsigned RETRY_COUNT    = 4,
    parameter int unsigned RETRY_INTERVAL = 250000000,
    parameter int unsigned POLL_INTERVAL  = 1024
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        arp_request_valid,
    output logic        arp_request_ready,
    input  logic [31:0] arp_request_ip,
    output logic        arp_response_valid,
    input  logic        arp_response_ready,
    output logic        arp_response_error,
    output logic [47:0] arp_response_mac,
    output logic        cache_query_valid,
    output logic [31:0] cache_query_ip,
    input  logic        cache_resp_valid,
    input  logic        cache_resp_error,
    input  logic [47:0] cache_resp_mac,
    output logic        arp_tx_valid,
    input  logic        arp_tx_ready,
    output logic [31:0] arp_tx_ip,
    input  logic [31:0] local_ip,
    input  logic [31:0] gateway_ip,
    input  logic [31:0] subnet_mask
);

    localparam logic [7:0]  RetryCount    = 8'(RETRY_COUNT);
    localparam logic [31:0] RetryInterval = 32'(RETRY_INTERVAL);
    localparam logic [15:0] PollInterval  = 16'(POLL_INTERVAL);

    typedef enum logic [2:0] {StIdle, StQuery, StSend, StWait, StResp} state_e;

    state_e      state_q, state_d;
    logic [31:0] lookup_ip_q, lookup_ip_d;
    logic [7:0]  retries_q, retries_d;
    logic        sent_q, sent_d;
    logic [31:0] retry_tmr_q, retry_tmr_d;
    logic [15:0] poll_q, poll_d;
    logic        resp_err_q, resp_err_d;
    logic [47:0] resp_mac_q, resp_mac_d;
    logic        req_ready_q, req_ready_d;
    logic        resp_valid_q, resp_valid_d;
    logic        query_valid_q, query_valid_d;
    logic [31:0] query_ip_q, query_ip_d;
    logic        tx_valid_q, tx_valid_d;
    logic [31:0] tx_ip_q, tx_ip_d;

    // Request classification against the configuration seen in the accept cycle
    logic        same_subnet;
    logic        is_bcast;
    logic [31:0] sel_ip;
    logic        accept;

    assign same_subnet = (arp_request_ip & subnet_mask) == (local_ip & subnet_mask);
    assign is_bcast    = (arp_request_ip == 32'hFFFF_FFFF) ||
                         (((arp_request_ip | subnet_mask) == 32'hFFFF_FFFF) && same_subnet);
    assign sel_ip      = same_subnet ? arp_request_ip : gateway_ip;
    // Ready is low in the first cycle after reset release even though state is idle
    assign accept      = arp_request_valid && req_ready_q;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and datapath update
    always_comb begin
        state_d     = state_q;
        lookup_ip_d = lookup_ip_q;
        retries_d   = retries_q;
        sent_d      = sent_q;
        retry_tmr_d = retry_tmr_q;
        poll_d      = poll_q;
        resp_err_d  = resp_err_q;
        resp_mac_d  = resp_mac_q;

        // Retry timer runs while waiting for a reply, saturating at zero
        if ((state_q == StQuery || state_q == StWait) && retry_tmr_q != 32'd0) begin
            retry_tmr_d = retry_tmr_q - 32'd1;
        end

        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    lookup_ip_d = sel_ip;
                    if (is_bcast) begin
                        resp_mac_d = 48'hFFFF_FFFF_FFFF;
                        resp_err_d = 1'b0;
                        state_d    = StResp;
                    end else if (sel_ip == 32'd0) begin
                        resp_mac_d = 48'd0;
                        resp_err_d = 1'b1;
                        state_d    = StResp;
                    end else begin
                        retries_d = RetryCount;
                        sent_d    = 1'b0;
                        state_d   = StQuery;
                    end
                end
            end
            StQuery: begin
                if (cache_resp_valid) begin
                    if (!cache_resp_error) begin
                        resp_mac_d = cache_resp_mac;
                        resp_err_d = 1'b0;
                        state_d    = StResp;
                    end else if (!sent_q) begin
                        state_d = StSend;
                    end else if (retry_tmr_q == 32'd0) begin
                        if (retries_q != 8'd0) begin
                            state_d = StSend;
                        end else begin
                            resp_mac_d = 48'd0;
                            resp_err_d = 1'b1;
                            state_d    = StResp;
                        end
                    end else begin
                        poll_d  = PollInterval;
                        state_d = StWait;
                    end
                end
            end
            StSend: begin
                if (arp_tx_ready) begin
                    retry_tmr_d = RetryInterval;
                    retries_d   = retries_q - 8'd1;
                    sent_d      = 1'b1;
                    poll_d      = PollInterval;
                    state_d     = StWait;
                end
            end
            StWait: begin
                if (poll_q == 16'd0) begin
                    state_d = StQuery;
                end else begin
                    poll_d = poll_q - 16'd1;
                end
            end
            StResp: begin
                if (arp_response_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Registered outputs derived from the upcoming state
    always_comb begin
        req_ready_d   = (state_d == StIdle);
        resp_valid_d  = (state_d == StResp);
        query_valid_d = (state_d == StQuery);
        tx_valid_d    = (state_d == StSend);
        query_ip_d    = query_ip_q;
        tx_ip_d       = tx_ip_q;
        if (state_d == StQuery) begin
            query_ip_d = lookup_ip_d;
        end
        if (state_d == StSend) begin
            tx_ip_d = lookup_ip_d;
        end
    end

    // Datapath and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lookup_ip_q   <= 32'd0;
            retries_q     <= 8'd0;
            sent_q        <= 1'b0;
            retry_tmr_q   <= 32'd0;
            poll_q        <= 16'd0;
            resp_err_q    <= 1'b0;
            resp_mac_q    <= 48'd0;
            req_ready_q   <= 1'b0;
            resp_valid_q  <= 1'b0;
            query_valid_q <= 1'b0;
            query_ip_q    <= 32'd0;
            tx_valid_q    <= 1'b0;
            tx_ip_q       <= 32'd0;
        end else begin
            lookup_ip_q   <= lookup_ip_d;
            retries_q     <= retries_d;
            sent_q        <= sent_d;
            retry_tmr_q   <= retry_tmr_d;
            poll_q        <= poll_d;
            resp_err_q    <= resp_err_d;
            resp_mac_q    <= resp_mac_d;
            req_ready_q   <= req_ready_d;
            resp_valid_q  <= resp_valid_d;
            query_valid_q <= query_valid_d;
            query_ip_q    <= query_ip_d;
            tx_valid_q    <= tx_valid_d;
            tx_ip_q       <= tx_ip_d;
        end
    end

    assign arp_request_ready  = req_ready_q;
    assign arp_response_valid = resp_valid_q;
    assign arp_response_error = resp_err_q;
    assign arp_response_mac   = resp_mac_q;
    assign cache_query_valid  = query_valid_q;
    assign cache_query_ip     = query_ip_q;
    assign arp_tx_valid       = tx_valid_q;
    assign arp_tx_ip          = tx_ip_q;

endmodule

// File: tb/tb_arp_lookup_ctrl.sv
// Bench for arp_lookup_ctrl: behavioural 3-cycle ARP cache, frame-generator
// sink, directed scenarios and a randomized phase against a rule-level model.
`timescale 1ns/1ps
module tb_arp_lookup_ctrl;

    localparam int unsigned RC = 2;
    localparam int unsigned RI = 100;
    localparam int unsigned PI = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        arp_request_valid = 1'b0;
    logic        arp_request_ready;
    logic [31:0] arp_request_ip = 32'd0;
    logic        arp_response_valid;
    logic        arp_response_ready = 1'b1;
    logic        arp_response_error;
    logic [47:0] arp_response_mac;
    logic        cache_query_valid;
    logic [31:0] cache_query_ip;
    logic        cache_resp_valid = 1'b0;
    logic        cache_resp_error = 1'b0;
    logic [47:0] cache_resp_mac = 48'd0;
    logic        arp_tx_valid;
    logic        arp_tx_ready = 1'b1;
    logic [31:0] arp_tx_ip;
    logic [31:0] local_ip = 32'h0A00_0001;
    logic [31:0] gateway_ip = 32'h0A00_00FE;
    logic [31:0] subnet_mask = 32'hFFFF_FF00;

    always #5 clk = ~clk;

    arp_lookup_ctrl #(
        .RETRY_COUNT   (RC),
        .RETRY_INTERVAL(RI),
        .POLL_INTERVAL (PI)
    ) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .arp_request_valid (arp_request_valid),
        .arp_request_ready (arp_request_ready),
        .arp_request_ip    (arp_request_ip),
        .arp_response_valid(arp_response_valid),
        .arp_response_ready(arp_response_ready),
        .arp_response_error(arp_response_error),
        .arp_response_mac  (arp_response_mac),
        .cache_query_valid (cache_query_valid),
        .cache_query_ip    (cache_query_ip),
        .cache_resp_valid  (cache_resp_valid),
        .cache_resp_error  (cache_resp_error),
        .cache_resp_mac    (cache_resp_mac),
        .arp_tx_valid      (arp_tx_valid),
        .arp_tx_ready      (arp_tx_ready),
        .arp_tx_ip         (arp_tx_ip),
        .local_ip          (local_ip),
        .gateway_ip        (gateway_ip),
        .subnet_mask       (subnet_mask)
    );

    logic [47:0] cache_tbl [logic [31:0]];
    int          n_cmp = 0;
    int          n_err = 0;
    int          cyc = 0;
    int          tx_cnt = 0;
    int          q_cnt = 0;
    logic [31:0] tx_last_ip = 32'd0;
    logic [31:0] q_last_ip = 32'd0;
    int          tx_times[$];
    logic        qv_prev = 1'b0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Cache: answers on the 4th consecutive cycle of a held query
    initial begin : cache_model
        int cnt;
        cnt = 0;
        forever begin
            @(posedge clk); #1;
            if (!rst_n || !cache_query_valid) begin
                cnt = 0;
                cache_resp_valid = 1'b0;
            end else begin
                cnt++;
                if (cnt == 4) begin
                    cache_resp_valid = 1'b1;
                    if (cache_tbl.exists(cache_query_ip)) begin
                        cache_resp_error = 1'b0;
                        cache_resp_mac   = cache_tbl[cache_query_ip];
                    end else begin
                        cache_resp_error = 1'b1;
                        cache_resp_mac   = 48'd0;
                    end
                end else begin
                    cache_resp_valid = 1'b0;
                end
            end
        end
    end

    // Monitor: counts ARP transmissions and distinct cache queries
    initial begin : monitor
        forever begin
            @(negedge clk); #1;
            cyc++;
            if (rst_n) begin
                if (arp_tx_valid && arp_tx_ready) begin
                    tx_cnt++;
                    tx_last_ip = arp_tx_ip;
                    tx_times.push_back(cyc);
                end
                if (cache_query_valid) begin
                    if (!qv_prev) q_cnt++;
                    q_last_ip = cache_query_ip;
                end
                qv_prev = cache_query_valid;
            end else begin
                qv_prev = 1'b0;
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference: expected outcome from the resolution rules alone
    task automatic ref_model(input logic [31:0] ip, input logic [31:0] loc,
                             input logic [31:0] gw, input logic [31:0] mask,
                             output logic err, output logic [47:0] mac, output int ntx);
        logic [31:0] target;
        ntx = 0;
        if (ip == 32'hFFFF_FFFF || ((ip | mask) == 32'hFFFF_FFFF && ((ip ^ loc) & mask) == 0)) begin
            err = 1'b0; mac = 48'hFFFF_FFFF_FFFF;
        end else begin
            target = (((ip ^ loc) & mask) == 0) ? ip : gw;
            if (target == 0) begin
                err = 1'b1; mac = 48'd0;
            end else if (cache_tbl.exists(target)) begin
                err = 1'b0; mac = cache_tbl[target];
            end else begin
                err = 1'b1; mac = 48'd0; ntx = RC;
            end
        end
    endtask

    // Called right after a posedge; returns right after the accepting posedge
    task automatic issue_req(input logic [31:0] ip);
        int g;
        g = 0;
        arp_request_valid = 1'b1;
        arp_request_ip    = ip;
        @(negedge clk);
        while (!arp_request_ready && g < 50) begin
            @(negedge clk);
            g++;
        end
        @(posedge clk); #1;
        arp_request_valid = 1'b0;
        arp_request_ip    = $urandom;
    endtask

    // lat counts cycles after the accept cycle (accept cycle = T)
    task automatic wait_resp(input int limit, output bit seen, output int lat, output logic rdy1);
        @(negedge clk);
        lat  = 1;
        rdy1 = arp_request_ready;
        while (!arp_response_valid && lat < limit) begin
            @(negedge clk);
            lat++;
        end
        seen = arp_response_valid;
    endtask

    task automatic do_lookup(input logic [31:0] ip, input int limit, output bit seen,
                             output int lat, output logic err, output logic [47:0] mac,
                             output logic rdy1);
        issue_req(ip);
        wait_resp(limit, seen, lat, rdy1);
        err = arp_response_error;
        mac = arp_response_mac;
        @(posedge clk); #1;
    endtask

    initial begin : stim
        bit          seen;
        int          lat;
        logic        err;
        logic [47:0] mac;
        logic        rdy1;
        int          t0;
        int          q0;
        int          gap;
        bit          stable;
        logic [31:0] ip;
        logic [31:0] sv_loc;
        logic [31:0] sv_gw;
        logic [31:0] sv_mask;
        logic        e_err;
        logic [47:0] e_mac;
        int          e_tx;
        logic [31:0] masks[3];

        masks[0] = 32'hFFFF_FF00;
        masks[1] = 32'hFFFF_0000;
        masks[2] = 32'hFFFF_FFF0;
        cache_tbl[32'h0A00_0005] = 48'h02_00_00_00_00_05;
        cache_tbl[32'h0A00_00FE] = 48'h02_00_00_00_00_FE;

        // Reset values
        repeat (3) @(negedge clk);
        check("reset_ready", arp_request_ready, 0);
        check("reset_resp", {arp_response_valid, arp_response_error, arp_response_mac}, 0);
        check("reset_query", {cache_query_valid, cache_query_ip}, 0);
        check("reset_tx", {arp_tx_valid, arp_tx_ip}, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("ready_before_first_edge", arp_request_ready, 0);
        @(negedge clk);
        check("ready_after_first_edge", arp_request_ready, 1);
        @(posedge clk); #1;

        // Cache hit on subnet host
        t0 = tx_cnt;
        do_lookup(32'h0A00_0005, 100, seen, lat, err, mac, rdy1);
        check("hit_seen", seen, 1);
        check("hit_latency", lat, 5);
        check("hit_ready_low_after_accept", rdy1, 0);
        check("hit_err", err, 0);
        check("hit_mac", mac, 48'h02_00_00_00_00_05);
        check("hit_valid_one_cycle", arp_response_valid, 0);
        check("hit_ready_back", arp_request_ready, 1);
        check("hit_no_tx", tx_cnt - t0, 0);

        // Off-subnet goes through the gateway
        do_lookup(32'h0808_0808, 100, seen, lat, err, mac, rdy1);
        check("gw_query_ip", q_last_ip, 32'h0A00_00FE);
        check("gw_latency", lat, 5);
        check("gw_err", err, 0);
        check("gw_mac", mac, 48'h02_00_00_00_00_FE);

        // Limited and directed broadcast bypass the cache
        q0 = q_cnt;
        do_lookup(32'hFFFF_FFFF, 100, seen, lat, err, mac, rdy1);
        check("bcast_latency", lat, 1);
        check("bcast_resp", {err, mac}, {1'b0, 48'hFFFF_FFFF_FFFF});
        do_lookup(32'h0A00_00FF, 100, seen, lat, err, mac, rdy1);
        check("dbcast_latency", lat, 1);
        check("dbcast_resp", {err, mac}, {1'b0, 48'hFFFF_FFFF_FFFF});
        check("bcast_no_query", q_cnt - q0, 0);

        // Zero gateway gives an immediate error
        gateway_ip = 32'd0;
        do_lookup(32'h0808_0404, 100, seen, lat, err, mac, rdy1);
        check("zero_latency", lat, 1);
        check("zero_resp", {err, mac}, {1'b1, 48'd0});
        gateway_ip = 32'h0A00_00FE;

        // Miss, one ARP request, reply lands in cache, next poll hits
        t0 = tx_cnt;
        fork
            do_lookup(32'h0A00_0009, 2000, seen, lat, err, mac, rdy1);
            begin
                repeat (40) @(posedge clk);
                cache_tbl[32'h0A00_0009] = 48'h02_00_00_00_00_09;
            end
        join
        check("reply_seen", seen, 1);
        check("reply_resp", {err, mac}, {1'b0, 48'h02_00_00_00_00_09});
        check("reply_tx_count", tx_cnt - t0, 1);
        check("reply_tx_ip", tx_last_ip, 32'h0A00_0009);

        // No reply: RC requests about RI apart, then error
        t0 = tx_cnt;
        do_lookup(32'h0A00_0077, 3000, seen, lat, err, mac, rdy1);
        check("timeout_seen", seen, 1);
        check("timeout_resp", {err, mac}, {1'b1, 48'd0});
        check("timeout_tx_count", tx_cnt - t0, RC);
        gap = (tx_times.size() >= 2) ?
              tx_times[tx_times.size()-1] - tx_times[tx_times.size()-2] : -1;
        check("timeout_tx_gap", (gap >= int'(RI) && gap <= int'(RI) + 30), 1);

        // Backpressure on the ARP command and on the response
        arp_tx_ready       = 1'b0;
        arp_response_ready = 1'b0;
        t0 = tx_cnt;
        issue_req(32'h0A00_0020);
        lat = 0;
        while (!arp_tx_valid && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        stable = 1'b1;
        repeat (20) begin
            @(negedge clk);
            if (!(arp_tx_valid && arp_tx_ip == 32'h0A00_0020)) stable = 1'b0;
        end
        check("tx_held_stable", stable, 1);
        check("tx_no_handshake", tx_cnt - t0, 0);
        @(posedge clk); #1;
        arp_tx_ready = 1'b1;
        wait_resp(3000, seen, lat, rdy1);
        err = arp_response_error;
        mac = arp_response_mac;
        check("bp_resp_seen", seen, 1);
        stable = 1'b1;
        repeat (10) begin
            @(negedge clk);
            if (!(arp_response_valid && arp_response_error == err && arp_response_mac == mac))
                stable = 1'b0;
        end
        check("resp_held_stable", stable, 1);
        check("bp_resp", {err, mac}, {1'b1, 48'd0});
        @(posedge clk); #1;
        arp_response_ready = 1'b1;
        @(posedge clk); #1;
        check("bp_resp_released", arp_response_valid, 0);

        // Reset while waiting between polls
        t0 = tx_cnt;
        issue_req(32'h0A00_0021);
        lat = 0;
        while (tx_cnt == t0 && lat < 50) begin
            @(posedge clk); #1;
            lat++;
        end
        check("rst_tx_sent", tx_cnt - t0, 1);
        repeat (5) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("rst_async_outputs", {arp_request_ready, arp_response_valid, arp_response_error,
              arp_response_mac, cache_query_valid, arp_tx_valid}, 0);
        check("rst_async_ips", {cache_query_ip, arp_tx_ip}, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        stable = 1'b1;
        repeat (60) begin
            @(negedge clk);
            if (arp_response_valid) stable = 1'b0;
        end
        check("rst_no_response", stable, 1);
        check("rst_ready_idle", arp_request_ready, 1);
        @(posedge clk); #1;

        // Randomized lookups, configuration scrambled after accept
        for (int i = 0; i < 12; i++) begin
            subnet_mask = masks[$urandom_range(0, 2)];
            case ($urandom_range(0, 5))
                0: ip = ($urandom_range(0, 1) == 0) ? 32'h0A00_0005 : 32'h0A00_0009;
                1: ip = (local_ip & subnet_mask) | ($urandom & ~subnet_mask);
                2: ip = 32'hC0A8_0000 | ($urandom & 32'h0000_FFFF);
                3: ip = 32'hFFFF_FFFF;
                4: ip = local_ip | ~subnet_mask;
                default: ip = $urandom;
            endcase
            ref_model(ip, local_ip, gateway_ip, subnet_mask, e_err, e_mac, e_tx);
            sv_loc  = local_ip;
            sv_gw   = gateway_ip;
            sv_mask = subnet_mask;
            t0 = tx_cnt;
            issue_req(ip);
            local_ip    = $urandom;
            gateway_ip  = $urandom;
            subnet_mask = $urandom;
            wait_resp(3000, seen, lat, rdy1);
            check("rand_seen", seen, 1);
            check($sformatf("rand_resp[%0d] ip=%0h", i, ip),
                  {arp_response_error, arp_response_mac}, {e_err, e_mac});
            @(posedge clk); #1;
            check($sformatf("rand_tx[%0d] ip=%0h", i, ip), tx_cnt - t0, e_tx);
            local_ip    = sv_loc;
            gateway_ip  = sv_gw;
            subnet_mask = sv_mask;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/arp_lookup_ctrl.md
# arp_lookup_ctrl

Resolution controller sitting directly upstream of the ARP cache: accepts next-hop MAC lookups from the IP transmit path, applies broadcast/subnet/gateway rules, queries the cache, and on a miss commands the ARP frame generator to transmit requests. It then polls the cache until a reply has been written or the retry budget is exhausted. One lookup is in flight at a time.

## Interface
- RETRY_COUNT, 4 — ARP requests sent before reporting failure (1..255)
- RETRY_INTERVAL, 250000000 — clk cycles between successive ARP requests (32-bit, ≥ POLL_INTERVAL)
- POLL_INTERVAL, 1024 — idle clk cycles between cache re-queries while waiting (16-bit, ≥1)

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- arp_request_valid  in  1  lookup request
- arp_request_ready  out  1  request accepted when valid&ready
- arp_request_ip  in  32  destination IP
- arp_response_valid  out  1  result valid
- arp_response_ready  in  1  result consumed
- arp_response_error  out  1  1 = unresolved
- arp_response_mac  out  48  resolved MAC
- cache_query_valid  out  1  to cache query_request_valid
- cache_query_ip  out  32  to cache query_request_ip
- cache_resp_valid  in  1  from cache query_response_valid
- cache_resp_error  in  1  from cache query_response_error
- cache_resp_mac  in  48  from cache query_response_mac
- arp_tx_valid  out  1  command: send ARP request
- arp_tx_ready  in  1  frame generator accepted command
- arp_tx_ip  out  32  target IP for ARP request
- local_ip  in  32  own address
- gateway_ip  in  32  default gateway
- subnet_mask  in  32  netmask

## Operation
- States: IDLE, QUERY, SEND, WAIT, RESP.
- IDLE: arp_request_ready=1. On handshake register IP, classify:
  - ip==32'hFFFFFFFF or (ip | mask)==32'hFFFFFFFF with (ip&mask)==(local_ip&mask): MAC=48'hFFFFFFFFFFFF, error=0 → RESP.
  - (ip&mask)==(local_ip&mask): lookup_ip=ip; else lookup_ip=gateway_ip.
  - lookup_ip==0: error=1 → RESP. Otherwise retries_left=RETRY_COUNT, sent=0 → QUERY.
- QUERY: cache_query_valid=1, cache_query_ip=lookup_ip held constant until cache_resp_valid. Cycle resp seen: cache_query_valid drops (next cycle 0, guaranteeing ≥1 low cycle to flush cache pipeline).
  - error=0 → capture MAC, error=0 → RESP.
  - miss, sent=0 → SEND.
  - miss, sent=1, retry timer==0: retries_left>0 → SEND; else error=1, MAC=0 → RESP.
  - miss otherwise → WAIT, poll counter=POLL_INTERVAL.
- SEND: arp_tx_valid=1, arp_tx_ip=lookup_ip until arp_tx_ready; on handshake retry timer=RETRY_INTERVAL, retries_left−1, sent=1, poll counter=POLL_INTERVAL → WAIT.
- WAIT: poll counter decrements; at 0 → QUERY.
- Retry timer decrements every cycle in WAIT and QUERY, saturates at 0.
- RESP: arp_response_valid=1 with error/MAC stable until arp_response_ready → IDLE.
- local_ip/gateway_ip/subnet_mask sampled only in the IDLE accept cycle; changes mid-lookup ignored.

## Timing
- Reset (async assert, sync release): state IDLE; arp_request_ready=0, arp_response_valid=0, arp_response_error=0, arp_response_mac=0, cache_query_valid=0, cache_query_ip=0, arp_tx_valid=0, arp_tx_ip=0, counters 0. arp_request_ready=1 first clk after release.
- All outputs registered. arp_request_ready=0 outside IDLE, including the accept+1 cycle.
- Cache latency 3 cycles with valid held. Hit: accept at cycle T, cache_query_valid at T+1, cache_resp_valid at T+4, arp_response_valid at T+5.
- Broadcast/zero-IP: arp_response_valid at T+1.
- RESP with arp_response_ready already high: valid for exactly 1 cycle; next request acceptable 1 cycle later.
- Reset mid-lookup: any pending arp_tx/cache query abandoned immediately; no response produced.
- Total failure time ≈ RETRY_COUNT×RETRY_INTERVAL plus poll/query granularity.

## Test plan
- Hit: cache preloaded 10.0.0.5→02:00:00:00:00:05, local 10.0.0.1/24, request 10.0.0.5 → response at T+5, error=0, mac=02:00:00:00:00:05, no arp_tx.
- Off-subnet: request 8.8.8.8, gateway 10.0.0.254 cached → cache_query_ip=0x0A0000FE, response MAC of gateway.
- Broadcast: request 255.255.255.255 and 10.0.0.255 → response at T+1, mac=FFFFFFFFFFFF, error=0, no cache query.
- Miss then reply: RETRY_INTERVAL=100, POLL_INTERVAL=16; 10.0.0.9 absent → one arp_tx with ip 0x0A000009; write cache entry 40 cycles later → next poll hits, error=0, only 1 arp_tx.
- Timeout: RETRY_COUNT=2, no reply → exactly 2 arp_tx ~100 cycles apart, then error=1, mac=0.
- Backpressure/reset: hold arp_tx_ready=0 20 cycles (valid and ip stable), hold arp_response_ready=0 (outputs stable); assert rst_n=0 in WAIT → all outputs reset values same cycle.
